// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c_slave_regs target: FSM states, bus
// ACK levels, bit-counter sizing and the majority-vote helper for the optional filter.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } i2c_slv_state_t;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

  localparam int BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = 3'd7;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA conditioning: 2-FF synchronizers, optional 3-sample majority filter
// (I2C_SLV_GLITCH_FILTER_EN) and registered edge / START / STOP detectors.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_s1_r, scl_s2_r, sda_s1_r, sda_s2_r;
  logic scl_cur_s, sda_cur_s;
  logic scl_prev_r, sda_prev_r;
  logic scl_rise_r, scl_fall_r, start_r, stop_r, sda_lvl_r;

  // Two-stage synchronizers; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_r <= 1'b1;
      scl_s2_r <= 1'b1;
      sda_s1_r <= 1'b1;
      sda_s2_r <= 1'b1;
    end else begin
      scl_s1_r <= scl_in;
      scl_s2_r <= scl_s1_r;
      sda_s1_r <= sda_in;
      sda_s2_r <= sda_s1_r;
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic scl_f1_r, scl_f2_r, sda_f1_r, sda_f2_r, scl_flt_r, sda_flt_r;

  // Majority vote over the last three synchronized samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_f1_r  <= 1'b1;
      scl_f2_r  <= 1'b1;
      sda_f1_r  <= 1'b1;
      sda_f2_r  <= 1'b1;
      scl_flt_r <= 1'b1;
      sda_flt_r <= 1'b1;
    end else begin
      scl_f1_r  <= scl_s2_r;
      scl_f2_r  <= scl_f1_r;
      sda_f1_r  <= sda_s2_r;
      sda_f2_r  <= sda_f1_r;
      scl_flt_r <= maj3(scl_s2_r, scl_f1_r, scl_f2_r);
      sda_flt_r <= maj3(sda_s2_r, sda_f1_r, sda_f2_r);
    end
  end

  assign scl_cur_s = scl_flt_r;
  assign sda_cur_s = sda_flt_r;
`else
  assign scl_cur_s = scl_s2_r;
  assign sda_cur_s = sda_s2_r;
`endif

  // Previous-sample copies and registered edge/condition pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
      scl_rise_r <= 1'b0;
      scl_fall_r <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
      sda_lvl_r  <= 1'b1;
    end else begin
      scl_prev_r <= scl_cur_s;
      sda_prev_r <= sda_cur_s;
      scl_rise_r <= scl_cur_s & ~scl_prev_r;
      scl_fall_r <= ~scl_cur_s & scl_prev_r;
      start_r    <= scl_cur_s & scl_prev_r & sda_prev_r & ~sda_cur_s;
      stop_r     <= scl_cur_s & scl_prev_r & ~sda_prev_r & sda_cur_s;
      sda_lvl_r  <= sda_cur_s;
    end
  end

  assign sda_lvl   = sda_lvl_r;
  assign scl_rise  = scl_rise_r;
  assign scl_fall  = scl_fall_r;
  assign start_det = start_r;
  assign stop_det  = stop_r;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a pointer-addressed register bank. Optional input glitch
// filter is enabled by defining I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 4,
  localparam int        PW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  wr_strobe,
  output logic [PW-1:0]         wr_idx,
  output logic                  busy
);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl),
    .sda_in    (sda),
    .sda_lvl   (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_slv_state_t         state_r;
  logic [BIT_CNT_W-1:0]   bit_cnt_r;
  logic [7:0]             shift_r;
  logic [7:0]             tx_r;
  logic [PW-1:0]          ptr_r;
  logic [8*NUM_REGS-1:0]  regs_r;
  logic                   rw_r;
  logic                   hold_r;
  logic                   sda_oe_r;
  logic                   wr_strobe_r;
  logic [PW-1:0]          wr_idx_r;
  logic                   busy_r;

  logic [7:0]    rx_byte_s;
  logic [PW-1:0] ptr_nxt_s;
  logic [7:0]    rd_byte_s;
  logic [7:0]    rd_nxt_byte_s;

  assign rx_byte_s     = {shift_r[6:0], sda_lvl};
  assign ptr_nxt_s     = ptr_r + {{(PW-1){1'b0}}, 1'b1};
  assign rd_byte_s     = regs_r[{ptr_r, 3'b000} +: 8];
  assign rd_nxt_byte_s = regs_r[{ptr_nxt_s, 3'b000} +: 8];

  // hold_r marks the second half of an ACK slot, or a finished read byte
  // awaiting the SCL fall that hands SDA to the master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= '0;
      shift_r     <= 8'h00;
      tx_r        <= 8'h00;
      ptr_r       <= '0;
      regs_r      <= '0;
      rw_r        <= 1'b0;
      hold_r      <= 1'b0;
      sda_oe_r    <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_idx_r    <= '0;
      busy_r      <= 1'b0;
    end else begin
      wr_strobe_r <= 1'b0;
      if (start_det) begin
        state_r   <= ST_ADDR;
        busy_r    <= 1'b1;
        bit_cnt_r <= '0;
        hold_r    <= 1'b0;
        sda_oe_r  <= 1'b0;
      end else if (stop_det) begin
        state_r  <= ST_IDLE;
        busy_r   <= 1'b0;
        hold_r   <= 1'b0;
        sda_oe_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            sda_oe_r <= 1'b0;
          end
          ST_ADDR: begin
            if (scl_rise) begin
              shift_r   <= rx_byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == BIT_LAST) begin
                if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                  rw_r    <= rx_byte_s[0];
                  hold_r  <= 1'b0;
                  state_r <= ST_ADDR_ACK;
                end else begin
                  state_r <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!hold_r) begin
                sda_oe_r <= 1'b1;
                hold_r   <= 1'b1;
              end else begin
                hold_r    <= 1'b0;
                bit_cnt_r <= '0;
                if (rw_r) begin
                  // First read bit goes out on the same fall that ends the ACK
                  sda_oe_r <= ~rd_byte_s[7];
                  tx_r     <= {rd_byte_s[6:0], 1'b0};
                  state_r  <= ST_RDATA;
                end else begin
                  sda_oe_r <= 1'b0;
                  state_r  <= ST_PTR;
                end
              end
            end
          end
          ST_PTR: begin
            if (scl_rise) begin
              shift_r   <= rx_byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == BIT_LAST) begin
                ptr_r   <= rx_byte_s[PW-1:0];
                hold_r  <= 1'b0;
                state_r <= ST_PTR_ACK;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!hold_r) begin
                sda_oe_r <= 1'b1;
                hold_r   <= 1'b1;
              end else begin
                sda_oe_r  <= 1'b0;
                hold_r    <= 1'b0;
                bit_cnt_r <= '0;
                state_r   <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (scl_rise) begin
              shift_r   <= rx_byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == BIT_LAST) begin
                regs_r[{ptr_r, 3'b000} +: 8] <= rx_byte_s;
                wr_strobe_r <= 1'b1;
                wr_idx_r    <= ptr_r;
                ptr_r       <= ptr_nxt_s;
                hold_r      <= 1'b0;
                state_r     <= ST_WDATA_ACK;
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == BIT_LAST) begin
                hold_r <= 1'b1;
              end
            end else if (scl_fall) begin
              if (hold_r) begin
                sda_oe_r <= 1'b0;
                hold_r   <= 1'b0;
                state_r  <= ST_RDATA_ACK;
              end else begin
                sda_oe_r <= ~tx_r[7];
                tx_r     <= {tx_r[6:0], 1'b0};
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == ACK_LVL) begin
                ptr_r     <= ptr_nxt_s;
                tx_r      <= rd_nxt_byte_s;
                bit_cnt_r <= '0;
                state_r   <= ST_RDATA;
              end else begin
                state_r <= ST_WAIT_STOP;
              end
            end
          end
          ST_WAIT_STOP: begin
            sda_oe_r <= 1'b0;
          end
          default: begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            sda_oe_r <= 1'b0;
            hold_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda       = sda_oe_r ? 1'b0 : 1'bz;
  assign regs      = regs_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_idx    = wr_idx_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Randomized bench for i2c_slave_regs: a bus master drives transactions, a
// transaction-level register model predicts results, a monitor checks writes.
module tb_i2c_slave_regs;
  localparam int NUM_REGS = 4;
  localparam int PW = 2;
  localparam logic [6:0] SADDR = 7'h50;

  logic clk = 1'b0;
  logic rst_n;
  logic scl;
  logic m_sda_low;
  wire  sda;
  logic [8*NUM_REGS-1:0] regs;
  logic wr_strobe;
  logic [PW-1:0] wr_idx;
  logic busy;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_regs #(.SLAVE_ADDR(SADDR), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .regs(regs), .wr_strobe(wr_strobe), .wr_idx(wr_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] model_regs [NUM_REGS];
  int model_ptr = 0;

  typedef struct {
    int idx;
    logic [8*NUM_REGS-1:0] bank;
  } wr_exp_t;
  wr_exp_t sb_q[$];

  function automatic logic [8*NUM_REGS-1:0] model_flat();
    logic [8*NUM_REGS-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[8*i +: 8] = model_regs[i];
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest predicted write
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && wr_strobe === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got strobe idx %0d expected none", wr_idx);
        end else begin
          e = sb_q.pop_front();
          check("wr_idx", 64'(wr_idx), 64'(e.idx));
          check("regs_after_write", 64'(regs), 64'(e.bank));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; tick(5);
    scl = 1'b1;       tick(5);
    m_sda_low = 1'b1; tick(5);
    scl = 1'b0;       tick(5);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; tick(5);
    scl = 1'b1;       tick(5);
    m_sda_low = 1'b0; tick(10);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; tick(5);
    scl = 1'b1;     tick(10);
    scl = 1'b0;     tick(5);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; tick(5);
    scl = 1'b1;       tick(5);
    b = sda;          tick(5);
    scl = 1'b0;       tick(5);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(master_ack);
  endtask

  task automatic write_txn(input logic [7:0] p, input logic [7:0] data[$]);
    logic ack;
    bus_start();
    write_byte({SADDR, 1'b0}, ack); check("wr_addr_ack", 64'(ack), 64'(0));
    write_byte(p, ack);             check("wr_ptr_ack", 64'(ack), 64'(0));
    model_ptr = p % NUM_REGS;
    foreach (data[k]) begin
      wr_exp_t e;
      model_regs[model_ptr] = data[k];
      e.idx = model_ptr;
      e.bank = model_flat();
      sb_q.push_back(e);
      model_ptr = (model_ptr + 1) % NUM_REGS;
      write_byte(data[k], ack);     check("wr_data_ack", 64'(ack), 64'(0));
    end
    bus_stop();
  endtask

  task automatic read_txn(input bit set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] got;
    bus_start();
    if (set_ptr) begin
      write_byte({SADDR, 1'b0}, ack); check("rd_waddr_ack", 64'(ack), 64'(0));
      write_byte(p, ack);             check("rd_ptr_ack", 64'(ack), 64'(0));
      model_ptr = p % NUM_REGS;
      bus_start();
    end
    write_byte({SADDR, 1'b1}, ack);   check("rd_addr_ack", 64'(ack), 64'(0));
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1) ? 1'b1 : 1'b0, got);
      check("rd_data", 64'(got), 64'(model_regs[(model_ptr + i) % NUM_REGS]));
    end
    model_ptr = (model_ptr + n - 1) % NUM_REGS;
    check("rd_sda_released", 64'(sda), 64'(1));
    bus_stop();
  endtask

  task automatic mismatch_txn(input logic [6:0] a, input logic rw, input logic [7:0] extra);
    logic ack;
    bus_start();
    write_byte({a, rw}, ack);  check("mm_addr_nack", 64'(ack), 64'(1));
    write_byte(extra, ack);    check("mm_extra_nack", 64'(ack), 64'(1));
    check("mm_busy_held", 64'(busy), 64'(1));
    bus_stop();
    check("mm_busy_after_stop", 64'(busy), 64'(0));
    check("mm_regs_unchanged", 64'(regs), 64'(model_flat()));
  endtask

  initial begin
    logic ack;
    logic [7:0] q[$];
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
    rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
    tick(5);
    check("rst_regs", 64'(regs), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_strobe", 64'(wr_strobe), 64'(0));
    check("rst_wr_idx", 64'(wr_idx), 64'(0));
    check("rst_sda", 64'(sda), 64'(1));
    rst_n = 1'b1;
    tick(5);

`ifdef I2C_SLV_GLITCH_FILTER_EN
    begin
      logic seen_busy;
      seen_busy = 1'b0;
      m_sda_low = 1'b1; tick(1);
      m_sda_low = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick(1);
        seen_busy = seen_busy | busy;
      end
      check("glitch_no_start", 64'(seen_busy), 64'(0));
    end
`endif

    // Directed cases from the test plan
    q = '{8'h5A};             write_txn(8'h01, q);
    check("wr_busy_idle", 64'(busy), 64'(0));
    q = '{8'h11, 8'h22};      write_txn(8'h03, q);
    q = '{8'hC3};             write_txn(8'h02, q);
    read_txn(1'b1, 8'h02, 2);
    mismatch_txn(7'h58, 1'b0, 8'hFF);

    // Randomized traffic against the register model
    for (int t = 0; t < 20; t++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          q.delete();
          for (int k = 0; k < $urandom_range(1, 4); k++) q.push_back(8'($urandom));
          write_txn(8'($urandom), q);
        end
        1: read_txn(1'b1, 8'($urandom), $urandom_range(1, 4));
        2: read_txn(1'b0, 8'h00, $urandom_range(1, 3));
        default: begin
          logic [6:0] a;
          a = 7'($urandom);
          if (a == SADDR) a = a ^ 7'h01;
          mismatch_txn(a, 1'($urandom), 8'($urandom));
        end
      endcase
    end

    // Reset while the target is driving a 0 data bit
    q = '{8'h3C};             write_txn(8'h02, q);
    bus_start();
    write_byte({SADDR, 1'b0}, ack); check("rr_waddr_ack", 64'(ack), 64'(0));
    write_byte(8'h02, ack);         check("rr_ptr_ack", 64'(ack), 64'(0));
    bus_start();
    write_byte({SADDR, 1'b1}, ack); check("rr_addr_ack", 64'(ack), 64'(0));
    check("rr_bit7_driven_low", 64'(sda), 64'(0));
    rst_n = 1'b0;
    #1;
    check("rr_sda_released", 64'(sda), 64'(1));
    tick(1);
    check("rr_regs_cleared", 64'(regs), 64'(0));
    check("rr_busy_cleared", 64'(busy), 64'(0));
    m_sda_low = 1'b0; scl = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(10);
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    q = '{8'h81};             write_txn(8'h00, q);
    read_txn(1'b0, 8'h00, 1);

    tick(20);
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
